pattern_scan_sched: RTL and testbench
=====================================

PATTERN_SCAN_SCHED -- requirements
Module: pattern_scan_sched

Interface
REQ-001 Parameter: W, 8, bits per scanned word (W >= 4).
REQ-002 Parameter: CNTW, 4, width of hit_cnt.
REQ-003 The block SHALL use one clock with asynchronous, active-low reset; ports: clk in 1 rising-edge clock; reset_n in 1 async active-low reset.
REQ-004 req in 2 level request per requester (bit i = requester i).
REQ-005 data0 in W word from requester 0; held stable while req[0]=1 until gnt[0].
REQ-006 data1 in W word from requester 1; held stable while req[1]=1 until gnt[1].
REQ-007 gnt out 2 one-cycle pulse; the word of requester i is captured in this cycle.
REQ-008 det_clr out 1 clear to the shared 1101 detector's reset input (active-high).
REQ-009 det_din out 1 serial bit to the shared detector's din.
REQ-010 det_hit in 1 shared detector's dout (Moore: reflects the bit driven in the previous cycle).
REQ-011 busy out 1 high in every state except IDLE.
REQ-012 done out 1 one-cycle pulse, scan result valid.
REQ-013 done_id out 1 requester index of the completed scan; held until next done.
REQ-014 hit_cnt out CNTW number of detections in the completed word; held until next done.

Function
REQ-015 FSM states SHALL be IDLE, CLR, SHIFT, DRAIN, DONE; all outputs driven from flops.
REQ-016 IDLE: no req -> stay; any req -> grant one requester, pulse gnt[i], capture its word into shift register, record id, go CLR.
REQ-017 Arbitration SHALL be round-robin: a favoured pointer starts at 0 after reset; on both req high the favoured requester wins; after any grant to i the pointer moves to the other requester.
REQ-018 A single req high SHALL be granted regardless of the pointer.
REQ-019 req asserted outside IDLE SHALL NOT be granted until the FSM returns to IDLE; no request is lost while held.
REQ-020 CLR: det_clr=1, det_din=0, internal hit counter cleared, bit index loaded to W-1; next SHIFT.
REQ-021 SHIFT: det_clr=0, det_din = current MSB of shift register, shift left one per cycle, MSB first; exactly W cycles; then DRAIN.
REQ-022 det_hit SHALL be counted in SHIFT cycles 2..W and in the DRAIN cycle (one-cycle detector latency); it is ignored in the first SHIFT cycle.
REQ-023 DRAIN: det_din=0; samples the hit for the last bit; next DONE.
REQ-024 DONE: done=1 for one cycle, hit_cnt and done_id updated; next IDLE.
REQ-025 Hit counter SHALL saturate at 2^CNTW-1, never wrap.
REQ-026 Latency SHALL be fixed: done asserts exactly W+3 cycles after the gnt cycle (11 for W=8); minimum spacing between grants is W+4 cycles.
REQ-027 Overlapping detections follow the detector (1101101 yields 2 hits); the block SHALL NOT reinterpret det_hit.

Reset
REQ-028 While reset_n=0: state IDLE, gnt=0, done=0, busy=0, done_id=0, hit_cnt=0, det_din=0, det_clr=1, pointer=0.
REQ-029 Reset assertion mid-scan SHALL abort immediately (asynchronous), discard the word and produce no done; det_clr stays 1 until the first post-reset clock edge.

Verification
REQ-030 req=01, data0=8'hD0 -> gnt=01 at cycle t, det_clr at t+1, done at t+11, done_id=0, hit_cnt=1.
REQ-031 req=10, data1=8'hDB -> done_id=1, hit_cnt=2 (overlap counted).
REQ-032 req=10, data1=8'h0D -> hit on final bit captured in DRAIN, hit_cnt=1; data 8'hFF -> hit_cnt=0.
REQ-033 req=11 held, data0=8'hFF, data1=8'hD0 -> grants alternate 0,1,0,1; results (id0,0),(id1,1) repeating; no gnt while busy=1.
REQ-034 reset_n low during SHIFT -> all outputs at REQ-028 values at once, no done; after release with req=11 requester 0 is granted first.

Source files
------------

// File: rtl/pattern_scan_sched.sv
// Two-requester round-robin scheduler that serialises each granted word MSB first
// into a shared external 1101 detector and reports the per-word hit count.
module pattern_scan_sched #(
    parameter int W    = 8,
    parameter int CNTW = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [1:0]      req,
    input  logic [W-1:0]    data0,
    input  logic [W-1:0]    data1,
    output logic [1:0]      gnt,
    output logic            det_clr,
    output logic            det_din,
    input  logic            det_hit,
    output logic            busy,
    output logic            done,
    output logic            done_id,
    output logic [CNTW-1:0] hit_cnt
);
    // state | meaning
    // IDLE  | waiting for a request; the gnt pulse is visible in this state
    // CLR   | detector held in clear, hit counter zeroed, bit index loaded
    // SHIFT | one word bit per cycle to the detector, MSB first (W cycles)
    // DRAIN | detector answer for the last bit is sampled
    // DONE  | result published; a waiting request may already be granted here
    typedef enum logic [2:0] {
        IDLE,
        CLR,
        SHIFT,
        DRAIN,
        DONE
    } state_t;

    localparam int              IW       = (W > 1) ? $clog2(W) : 1;
    localparam logic [IW-1:0]   IDX_LAST = IW'(W - 1);
    localparam logic [IW-1:0]   IDX_ONE  = IW'(1);
    localparam logic [CNTW-1:0] CNT_MAX  = '1;
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);

    state_t          state;
    state_t          state_nxt;
    logic            ptr;
    logic            scan_id;
    logic            grant_ok;
    logic            grant_win;
    logic            pick;
    logic            cnt_en;
    logic [W-1:0]    sreg;
    logic [IW-1:0]   idx;
    logic [CNTW-1:0] cnt;
    logic [CNTW-1:0] cnt_nxt;

    always_comb begin
        state_nxt = state;
        grant_ok  = 1'b0;
        cnt_en    = 1'b0;
        pick      = ptr;
        case (state)
            IDLE: begin
                grant_ok = (gnt == 2'b00);
                if (gnt != 2'b00) state_nxt = CLR;
            end
            CLR:   state_nxt = SHIFT;
            SHIFT: begin
                // the first SHIFT cycle still sees the cleared detector
                cnt_en = (idx != IDX_LAST);
                if (idx == '0) state_nxt = DRAIN;
            end
            DRAIN: begin
                cnt_en    = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                grant_ok  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (req != 2'b11) pick = req[1];
        grant_win = grant_ok && (req != 2'b00);
        cnt_nxt   = cnt;
        if (cnt_en && det_hit && (cnt != CNT_MAX)) cnt_nxt = cnt + CNT_ONE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            gnt     <= 2'b00;
            ptr     <= 1'b0;
            scan_id <= 1'b0;
            sreg    <= '0;
            idx     <= '0;
            cnt     <= '0;
            det_clr <= 1'b1;
            det_din <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            done_id <= 1'b0;
            hit_cnt <= '0;
        end else begin
            state   <= state_nxt;
            gnt     <= grant_win ? (pick ? 2'b10 : 2'b01) : 2'b00;
            det_clr <= (state_nxt == CLR);
            busy    <= (state_nxt != IDLE);
            done    <= (state_nxt == DONE);
            det_din <= 1'b0;
            if (grant_win) begin
                scan_id <= pick;
                ptr     <= ~pick;
            end
            if (state_nxt == SHIFT) begin
                det_din <= sreg[W-1];
                sreg    <= {sreg[W-2:0], 1'b0};
            end else if (grant_win) begin
                sreg <= pick ? data1 : data0;
            end
            if (state == CLR) begin
                idx <= IDX_LAST;
                cnt <= '0;
            end else begin
                if (state == SHIFT) idx <= idx - IDX_ONE;
                cnt <= cnt_nxt;
            end
            if (state_nxt == DONE) begin
                hit_cnt <= cnt_nxt;
                done_id <= scan_id;
            end
        end
    end

endmodule

// File: tb/tb_pattern_scan_sched.sv
// Bench for pattern_scan_sched: behavioural 1101 detectors, a grant/result
// scoreboard, a vector table and hand sequences for alternation, reset and saturation.
module tb_pattern_scan_sched;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  req;
    logic [7:0]  data0, data1;
    logic [1:0]  gnt;
    logic        det_clr, det_din, det_hit, busy, done, done_id;
    logic [3:0]  hit_cnt;

    logic [1:0]  req2;
    logic [15:0] d2a;
    logic [15:0] d2b = 16'h0000;
    logic [1:0]  gnt2;
    logic        det_clr2, det_din2, det_hit2, busy2, done2, done_id2;
    logic [1:0]  hit_cnt2;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    pattern_scan_sched #(.W(8), .CNTW(4)) u_dut (
        .clk(clk), .reset_n(reset_n), .req(req), .data0(data0), .data1(data1),
        .gnt(gnt), .det_clr(det_clr), .det_din(det_din), .det_hit(det_hit),
        .busy(busy), .done(done), .done_id(done_id), .hit_cnt(hit_cnt)
    );

    pattern_scan_sched #(.W(16), .CNTW(2)) u_sat (
        .clk(clk), .reset_n(reset_n), .req(req2), .data0(d2a), .data1(d2b),
        .gnt(gnt2), .det_clr(det_clr2), .det_din(det_din2), .det_hit(det_hit2),
        .busy(busy2), .done(done2), .done_id(done_id2), .hit_cnt(hit_cnt2)
    );

    // Moore 1101 detector with overlap; state 4 means a match was just completed
    function automatic logic [2:0] det_next(input logic [2:0] s, input logic b);
        case (s)
            3'd0:    return b ? 3'd1 : 3'd0;
            3'd1:    return b ? 3'd2 : 3'd0;
            3'd2:    return b ? 3'd2 : 3'd3;
            3'd3:    return b ? 3'd4 : 3'd0;
            default: return b ? 3'd2 : 3'd0;
        endcase
    endfunction

    logic [2:0] dst  = 3'd0;
    logic [2:0] dst2 = 3'd0;
    always @(posedge clk) dst  <= det_clr  ? 3'd0 : det_next(dst,  det_din);
    always @(posedge clk) dst2 <= det_clr2 ? 3'd0 : det_next(dst2, det_din2);
    assign det_hit  = (dst  == 3'd4);
    assign det_hit2 = (dst2 == 3'd4);

    function automatic int count_1101(input logic [63:0] w, input int width);
        int c = 0;
        for (int i = width - 1; i >= 3; i--)
            if (w[i] && w[i-1] && !w[i-2] && w[i-3]) c++;
        return c;
    endfunction

    function automatic int sat(input int c, input int m);
        return (c > m) ? m : c;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s actual=timeout required=event (t=%0t)", name, $time);
    endtask

    // which: 0 gnt, 1 done, 2 gnt2, 3 done2; returns at the negedge where it is seen
    task automatic wait_evt(input int which, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if ((which == 0 && gnt != 2'b00) || (which == 1 && done) ||
                (which == 2 && gnt2 != 2'b00) || (which == 3 && done2)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout($sformatf("wait_evt%0d", which));
    endtask

    typedef struct {
        logic id;
        int   cnt;
        int   cyc;
    } exp_t;
    exp_t sb[$];
    logic m_ptr;
    logic gnt_prev;

    always @(negedge clk or negedge reset_n) begin
        exp_t e;
        logic [1:0] exp_g;
        if (!reset_n) begin
            sb.delete();
            m_ptr    = 1'b0;
            gnt_prev = 1'b0;
        end else begin
            if (gnt_prev) chk("det_clr_after_gnt", int'(det_clr), 1);
            gnt_prev = (gnt != 2'b00);
            if (gnt != 2'b00) begin
                exp_g = (req == 2'b11) ? (m_ptr ? 2'b10 : 2'b01) : (req[1] ? 2'b10 : 2'b01);
                chk("sb_gnt", int'(gnt), int'(exp_g));
                chk("gnt_while_busy", int'(busy), 0);
                e.id  = gnt[1];
                e.cnt = sat(count_1101({56'd0, gnt[1] ? data1 : data0}, 8), 15);
                e.cyc = cyc;
                sb.push_back(e);
                m_ptr = ~gnt[1];
            end
            if (done) begin
                if (sb.size() == 0) begin
                    timeout("sb_unexpected_done");
                end else begin
                    e = sb.pop_front();
                    chk("sb_done_id", int'(done_id), int'(e.id));
                    chk("sb_hit_cnt", int'(hit_cnt), e.cnt);
                    chk("sb_latency", cyc - e.cyc, 11);
                end
            end
        end
    end

    typedef struct {
        logic [1:0] req;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       id;
        int         cnt;
    } vec_t;
    vec_t tbl[7];

    initial begin
        bit ok;
        int last;
        logic [15:0] sw[4];

        tbl[0] = '{2'b01, 8'hD0, 8'h00, 1'b0, 1};
        tbl[1] = '{2'b10, 8'h00, 8'hDB, 1'b1, 2};
        tbl[2] = '{2'b10, 8'h00, 8'h0D, 1'b1, 1};
        tbl[3] = '{2'b10, 8'h00, 8'hFF, 1'b1, 0};
        tbl[4] = '{2'b01, 8'h6D, 8'h00, 1'b0, 2};
        tbl[5] = '{2'b11, 8'h0D, 8'hDB, 1'b1, 2};
        tbl[6] = '{2'b11, 8'hD0, 8'h00, 1'b0, 1};
        sw[0] = 16'hDB6D;
        sw[1] = 16'hDB0D;
        sw[2] = 16'h000D;
        sw[3] = 16'h0000;

        reset_n = 1'b0;
        req = 2'b00; data0 = 8'h00; data1 = 8'h00;
        req2 = 2'b00; d2a = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_det_clr", int'(det_clr), 1);
        chk("rst_det_din", int'(det_din), 0);
        chk("rst_done_id", int'(done_id), 0);
        chk("rst_hit_cnt", int'(hit_cnt), 0);
        @(posedge clk); #1 reset_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            req = tbl[i].req; data0 = tbl[i].d0; data1 = tbl[i].d1;
            wait_evt(0, ok);
            if (!ok) break;
            chk($sformatf("tbl%0d_gnt", i), int'(gnt), tbl[i].id ? 2 : 1);
            @(posedge clk); #1 req = 2'b00;
            wait_evt(1, ok);
            if (!ok) break;
            chk($sformatf("tbl%0d_done_id", i), int'(done_id), int'(tbl[i].id));
            chk($sformatf("tbl%0d_hit_cnt", i), int'(hit_cnt), tbl[i].cnt);
        end

        // both requesters held: grants alternate from requester 0 after reset
        @(posedge clk); #1 reset_n = 1'b0;
        @(posedge clk); #1 reset_n = 1'b1;
        data0 = 8'hFF; data1 = 8'hD0; req = 2'b11;
        last = 0;
        for (int k = 0; k < 4; k++) begin
            wait_evt(0, ok);
            if (!ok) break;
            chk("alt_gnt", int'(gnt), (k % 2 == 1) ? 2 : 1);
            if (k > 0) chk("alt_spacing", cyc - last, 12);
            last = cyc;
            if (k == 3) begin
                @(posedge clk); #1 req = 2'b00;
            end
            wait_evt(1, ok);
            if (!ok) break;
            chk("alt_done_id", int'(done_id), k % 2);
            chk("alt_hit_cnt", int'(hit_cnt), k % 2);
        end

        // reset in the middle of SHIFT aborts the scan
        @(posedge clk); #1;
        req = 2'b01; data0 = 8'hD0;
        wait_evt(0, ok);
        @(posedge clk); #1 req = 2'b00;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("abort_gnt", int'(gnt), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_det_clr", int'(det_clr), 1);
        chk("abort_det_din", int'(det_din), 0);
        chk("abort_done_id", int'(done_id), 0);
        chk("abort_hit_cnt", int'(hit_cnt), 0);
        for (int n = 0; n < 14; n++) begin
            @(negedge clk);
            chk("abort_no_done", int'(done), 0);
        end
        @(posedge clk); #1;
        reset_n = 1'b1; req = 2'b11; data0 = 8'hD0; data1 = 8'hFF;
        wait_evt(0, ok);
        chk("post_rst_gnt", int'(gnt), 1);
        @(posedge clk); #1 req = 2'b00;
        wait_evt(1, ok);
        chk("post_rst_done_id", int'(done_id), 0);
        chk("post_rst_hit_cnt", int'(hit_cnt), 1);

        // narrow counter on a 16-bit word: saturation at 3
        for (int j = 0; j < 4; j++) begin
            @(posedge clk); #1;
            req2 = 2'b01; d2a = sw[j];
            wait_evt(2, ok);
            if (!ok) break;
            @(posedge clk); #1 req2 = 2'b00;
            wait_evt(3, ok);
            if (!ok) break;
            chk($sformatf("sat%0d_hit_cnt", j), int'(hit_cnt2), sat(count_1101({48'd0, sw[j]}, 16), 3));
        end

        repeat (3) @(posedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
